// File: rtl/decode_dispatch_align.sv
// Compressed-block decode front/back end: dispatches each word to its mode
// decoder by header and re-aligns the fixed-latency returns into one ordered stream.
module decode_dispatch_align #(
  parameter int unsigned            DATA_W    = 64,
  parameter int unsigned            NUM_MODES = 4,
  parameter int unsigned            PIX_W     = 24,
  parameter int unsigned            PIX_N     = 8,
  parameter int unsigned            BLK_COLS  = 180,
  parameter int unsigned            BLK_ROWS  = 780,
  parameter logic [4*NUM_MODES-1:0] MODE_LAT  = {4'd6, 4'd5, 4'd4, 4'd6}
) (
  input  logic                                 clk_in,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  input  logic [DATA_W-1:0]                    in_data,
  output logic [NUM_MODES-1:0]                 disp_valid,
  output logic [DATA_W-1:0]                    disp_data,
  output logic [$clog2(BLK_COLS)-1:0]          disp_col,
  output logic [$clog2(BLK_ROWS)-1:0]          disp_row,
  input  logic [NUM_MODES-1:0]                 ret_valid,
  input  logic [NUM_MODES*PIX_N*PIX_W-1:0]     ret_pix,
  output logic                                 out_valid,
  output logic [PIX_N*PIX_W-1:0]               out_pix,
  output logic [$clog2(NUM_MODES)-1:0]         out_mode,
  output logic [$clog2(BLK_COLS)-1:0]          out_col,
  output logic [$clog2(BLK_ROWS)-1:0]          out_row,
  output logic                                 out_sof,
  output logic                                 out_eol,
  output logic                                 out_eof,
  output logic                                 err_missing,
  output logic                                 err_unexpected,
  input  logic                                 clr_err
);

  function automatic int unsigned lat_of(input int unsigned m);
    return 32'(MODE_LAT[4*m +: 4]);
  endfunction

  function automatic int unsigned max_lat_f();
    int unsigned mx = 0;
    for (int unsigned m = 0; m < NUM_MODES; m++) begin
      if (lat_of(m) > mx) mx = lat_of(m);
    end
    return mx;
  endfunction

  localparam int unsigned HDR_W   = $clog2(NUM_MODES);
  localparam int unsigned COL_W   = $clog2(BLK_COLS);
  localparam int unsigned ROW_W   = $clog2(BLK_ROWS);
  localparam int unsigned BLK_W   = PIX_N * PIX_W;
  localparam int unsigned MAX_LAT = max_lat_f();

  logic [HDR_W-1:0] hdr;
  assign hdr = in_data[DATA_W-1 -: HDR_W];

  // Block position counters, advanced once per accepted word
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      if (col_q == COL_W'(BLK_COLS - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(BLK_ROWS - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Dispatch register shared by all mode decoders
  logic [NUM_MODES-1:0] disp_valid_q, disp_valid_d;
  logic [DATA_W-1:0]    disp_data_q,  disp_data_d;
  logic [COL_W-1:0]     disp_col_q,   disp_col_d;
  logic [ROW_W-1:0]     disp_row_q,   disp_row_d;

  always_comb begin
    disp_valid_d = '0;
    disp_data_d  = disp_data_q;
    disp_col_d   = disp_col_q;
    disp_row_d   = disp_row_q;
    if (in_valid) begin
      disp_valid_d = NUM_MODES'(1) << hdr;
      disp_data_d  = in_data;
      disp_col_d   = col_q;
      disp_row_d   = row_q;
    end
  end

  // Tag pipeline: stage k holds the word dispatched k cycles ago
  logic             tag_vld_q  [MAX_LAT+1];
  logic             tag_vld_d  [MAX_LAT+1];
  logic [HDR_W-1:0] tag_mode_q [MAX_LAT+1];
  logic [HDR_W-1:0] tag_mode_d [MAX_LAT+1];
  logic [COL_W-1:0] tag_col_q  [MAX_LAT+1];
  logic [COL_W-1:0] tag_col_d  [MAX_LAT+1];
  logic [ROW_W-1:0] tag_row_q  [MAX_LAT+1];
  logic [ROW_W-1:0] tag_row_d  [MAX_LAT+1];

  always_comb begin
    tag_vld_d[0]  = in_valid;
    tag_mode_d[0] = hdr;
    tag_col_d[0]  = col_q;
    tag_row_d[0]  = row_q;
    for (int unsigned k = 1; k <= MAX_LAT; k++) begin
      tag_vld_d[k]  = tag_vld_q[k-1];
      tag_mode_d[k] = tag_mode_q[k-1];
      tag_col_d[k]  = tag_col_q[k-1];
      tag_row_d[k]  = tag_row_q[k-1];
    end
  end

  logic [NUM_MODES-1:0] expected;
  logic [NUM_MODES-1:0] accept;
  logic [NUM_MODES-1:0] algn_vld;
  logic [BLK_W-1:0]     algn_pix [NUM_MODES];

  // Per-mode return check and delay line padding every mode up to MAX_LAT
  for (genvar m = 0; m < NUM_MODES; m++) begin : g_mode
    localparam int unsigned LAT = lat_of(m);
    localparam int unsigned DLY = MAX_LAT - LAT;

    logic [BLK_W-1:0] pix_in;
    assign pix_in      = ret_pix[m*BLK_W +: BLK_W];
    assign expected[m] = tag_vld_q[LAT] && (tag_mode_q[LAT] == HDR_W'(m));
    assign accept[m]   = ret_valid[m] & expected[m];

    if (DLY == 0) begin : g_wire
      assign algn_vld[m] = accept[m];
      assign algn_pix[m] = pix_in;
    end else begin : g_line
      logic             dl_vld_q [DLY];
      logic             dl_vld_d [DLY];
      logic [BLK_W-1:0] dl_pix_q [DLY];
      logic [BLK_W-1:0] dl_pix_d [DLY];

      always_comb begin
        dl_vld_d[0] = accept[m];
        dl_pix_d[0] = accept[m] ? pix_in : '0;
        for (int unsigned i = 1; i < DLY; i++) begin
          dl_vld_d[i] = dl_vld_q[i-1];
          dl_pix_d[i] = dl_pix_q[i-1];
        end
      end

      always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < DLY; i++) begin
            dl_vld_q[i] <= 1'b0;
            dl_pix_q[i] <= '0;
          end
        end else begin
          for (int unsigned i = 0; i < DLY; i++) begin
            dl_vld_q[i] <= dl_vld_d[i];
            dl_pix_q[i] <= dl_pix_d[i];
          end
        end
      end

      assign algn_vld[m] = dl_vld_q[DLY-1];
      assign algn_pix[m] = dl_pix_q[DLY-1];
    end
  end

  // Sticky error flags; a new error wins over a simultaneous clear
  logic err_missing_q, err_missing_d;
  logic err_unexpected_q, err_unexpected_d;

  always_comb begin
    err_missing_d    = (err_missing_q & ~clr_err) | (|(expected & ~ret_valid));
    err_unexpected_d = (err_unexpected_q & ~clr_err) | (|(ret_valid & ~expected));
  end

  // Output register fed from the last tag stage
  logic             out_valid_q, out_valid_d;
  logic [BLK_W-1:0] out_pix_q,   out_pix_d;
  logic [HDR_W-1:0] out_mode_q,  out_mode_d;
  logic [COL_W-1:0] out_col_q,   out_col_d;
  logic [ROW_W-1:0] out_row_q,   out_row_d;
  logic             out_sof_q,   out_sof_d;
  logic             out_eol_q,   out_eol_d;
  logic             out_eof_q,   out_eof_d;
  logic [HDR_W-1:0] fin_mode;
  logic [COL_W-1:0] fin_col;
  logic [ROW_W-1:0] fin_row;

  assign fin_mode = tag_mode_q[MAX_LAT];
  assign fin_col  = tag_col_q[MAX_LAT];
  assign fin_row  = tag_row_q[MAX_LAT];

  always_comb begin
    out_valid_d = tag_vld_q[MAX_LAT];
    out_pix_d   = out_pix_q;
    out_mode_d  = out_mode_q;
    out_col_d   = out_col_q;
    out_row_d   = out_row_q;
    out_sof_d   = 1'b0;
    out_eol_d   = 1'b0;
    out_eof_d   = 1'b0;
    if (tag_vld_q[MAX_LAT]) begin
      out_mode_d = fin_mode;
      out_col_d  = fin_col;
      out_row_d  = fin_row;
      out_sof_d  = (fin_col == '0) && (fin_row == '0);
      out_eol_d  = (fin_col == COL_W'(BLK_COLS - 1));
      out_eof_d  = out_eol_d && (fin_row == ROW_W'(BLK_ROWS - 1));
      out_pix_d  = algn_vld[fin_mode] ? algn_pix[fin_mode] : '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      col_q            <= '0;
      row_q            <= '0;
      disp_valid_q     <= '0;
      disp_data_q      <= '0;
      disp_col_q       <= '0;
      disp_row_q       <= '0;
      for (int unsigned k = 0; k <= MAX_LAT; k++) begin
        tag_vld_q[k]  <= 1'b0;
        tag_mode_q[k] <= '0;
        tag_col_q[k]  <= '0;
        tag_row_q[k]  <= '0;
      end
      err_missing_q    <= 1'b0;
      err_unexpected_q <= 1'b0;
      out_valid_q      <= 1'b0;
      out_pix_q        <= '0;
      out_mode_q       <= '0;
      out_col_q        <= '0;
      out_row_q        <= '0;
      out_sof_q        <= 1'b0;
      out_eol_q        <= 1'b0;
      out_eof_q        <= 1'b0;
    end else begin
      col_q            <= col_d;
      row_q            <= row_d;
      disp_valid_q     <= disp_valid_d;
      disp_data_q      <= disp_data_d;
      disp_col_q       <= disp_col_d;
      disp_row_q       <= disp_row_d;
      for (int unsigned k = 0; k <= MAX_LAT; k++) begin
        tag_vld_q[k]  <= tag_vld_d[k];
        tag_mode_q[k] <= tag_mode_d[k];
        tag_col_q[k]  <= tag_col_d[k];
        tag_row_q[k]  <= tag_row_d[k];
      end
      err_missing_q    <= err_missing_d;
      err_unexpected_q <= err_unexpected_d;
      out_valid_q      <= out_valid_d;
      out_pix_q        <= out_pix_d;
      out_mode_q       <= out_mode_d;
      out_col_q        <= out_col_d;
      out_row_q        <= out_row_d;
      out_sof_q        <= out_sof_d;
      out_eol_q        <= out_eol_d;
      out_eof_q        <= out_eof_d;
    end
  end

  assign disp_valid     = disp_valid_q;
  assign disp_data      = disp_data_q;
  assign disp_col       = disp_col_q;
  assign disp_row       = disp_row_q;
  assign out_valid      = out_valid_q;
  assign out_pix        = out_pix_q;
  assign out_mode       = out_mode_q;
  assign out_col        = out_col_q;
  assign out_row        = out_row_q;
  assign out_sof        = out_sof_q;
  assign out_eol        = out_eol_q;
  assign out_eof        = out_eof_q;
  assign err_missing    = err_missing_q;
  assign err_unexpected = err_unexpected_q;

endmodule

// File: tb/tb_decode_dispatch_align.sv
// Scoreboard bench for decode_dispatch_align with behavioural mode decoders
// returning at their fixed latencies.
module tb_decode_dispatch_align;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned NUM_MODES = 4;
  localparam int unsigned PIX_W     = 24;
  localparam int unsigned PIX_N     = 8;
  localparam int unsigned COLS      = 180;
  localparam int unsigned ROWS      = 6;   // short frame keeps the wrap test brief
  localparam int unsigned COL_W     = $clog2(COLS);
  localparam int unsigned ROW_W     = $clog2(ROWS);
  localparam int unsigned BLK_W     = PIX_N * PIX_W;
  localparam int          LAT_TOTAL = 8;

  typedef struct {
    int               mode;
    int               col;
    int               row;
    bit               sof;
    bit               eol;
    bit               eof;
    logic [BLK_W-1:0] pix;
    int               cyc;
  } exp_t;

  typedef struct {
    int               due;
    int               mode;
    logic [BLK_W-1:0] pix;
  } ret_t;

  logic                       clk_in = 1'b0;
  logic                       rst_n;
  logic                       in_valid;
  logic [DATA_W-1:0]          in_data;
  logic [NUM_MODES-1:0]       disp_valid;
  logic [DATA_W-1:0]          disp_data;
  logic [COL_W-1:0]           disp_col;
  logic [ROW_W-1:0]           disp_row;
  logic [NUM_MODES-1:0]       ret_valid;
  logic [NUM_MODES*BLK_W-1:0] ret_pix;
  logic                       out_valid;
  logic [BLK_W-1:0]           out_pix;
  logic [1:0]                 out_mode;
  logic [COL_W-1:0]           out_col;
  logic [ROW_W-1:0]           out_row;
  logic                       out_sof, out_eol, out_eof;
  logic                       err_missing, err_unexpected;
  logic                       clr_err;

  int   n_run = 0;
  int   n_fail = 0;
  int   n_out = 0;
  int   cyc = 0;
  int   m_col = 0;
  int   m_row = 0;
  bit   spur_req = 1'b0;
  exp_t sb[$];
  ret_t pend[$];

  decode_dispatch_align #(
    .BLK_COLS (COLS),
    .BLK_ROWS (ROWS)
  ) u_dut (
    .clk_in         (clk_in),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .disp_valid     (disp_valid),
    .disp_data      (disp_data),
    .disp_col       (disp_col),
    .disp_row       (disp_row),
    .ret_valid      (ret_valid),
    .ret_pix        (ret_pix),
    .out_valid      (out_valid),
    .out_pix        (out_pix),
    .out_mode       (out_mode),
    .out_col        (out_col),
    .out_row        (out_row),
    .out_sof        (out_sof),
    .out_eol        (out_eol),
    .out_eof        (out_eof),
    .err_missing    (err_missing),
    .err_unexpected (err_unexpected),
    .clr_err        (clr_err)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [BLK_W-1:0] got, input logic [BLK_W-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int m);
    case (m)
      0: return 6;
      1: return 4;
      2: return 5;
      default: return 6;
    endcase
  endfunction

  function automatic logic [BLK_W-1:0] pix_of(input logic [PIX_W-1:0] p0);
    logic [BLK_W-1:0] r;
    for (int i = 0; i < PIX_N; i++) r[i*PIX_W +: PIX_W] = p0 + PIX_W'(i * 65536);
    return r;
  endfunction

  // Decoder models and output monitor, sampled 2 units after the rising edge
  initial begin
    ret_t keep[$];
    ret_t r;
    exp_t e;
    ret_valid = '0;
    ret_pix   = '0;
    forever begin
      @(posedge clk_in);
      #2;
      ret_valid = '0;
      keep.delete();
      foreach (pend[i]) begin
        if (pend[i].due == cyc) begin
          ret_valid[pend[i].mode] = 1'b1;
          ret_pix[pend[i].mode*BLK_W +: BLK_W] = pend[i].pix;
        end else begin
          keep.push_back(pend[i]);
        end
      end
      pend = keep;
      if (spur_req) begin
        ret_valid[3] = 1'b1;
        ret_pix[3*BLK_W +: BLK_W] = '1;
      end
      if (rst_n) begin
        for (int m = 0; m < NUM_MODES; m++) begin
          if (disp_valid[m] && !disp_data[40]) begin
            r.due  = cyc + lat_of(m);
            r.mode = m;
            r.pix  = pix_of(disp_data[23:0]);
            pend.push_back(r);
          end
        end
        if (in_valid) begin
          check("disp_valid", disp_valid, 4'b0001 << in_data[63:62]);
          check("disp_data", disp_data, in_data);
        end else begin
          check("disp_idle", disp_valid, 4'b0000);
        end
        if (out_valid) begin
          n_out++;
          if (sb.size() == 0) begin
            check("out_unexpected", out_valid, 1'b0);
          end else begin
            e = sb.pop_front();
            check("out_mode", out_mode, e.mode);
            check("out_col", out_col, e.col);
            check("out_row", out_row, e.row);
            check("out_flags", {out_sof, out_eol, out_eof}, {e.sof, e.eol, e.eof});
            check("out_pix", out_pix, e.pix);
            check("out_latency", cyc - e.cyc, LAT_TOTAL);
          end
        end else begin
          check("idle_flags", {out_sof, out_eol, out_eof}, 3'b000);
        end
      end
    end
  end

  task automatic send(input int mode, input int p0, input bit drop);
    exp_t e;
    in_valid       = 1'b1;
    in_data        = '0;
    in_data[63:62] = 2'(mode);
    in_data[40]    = drop;
    in_data[23:0]  = 24'(p0);
    e.mode = mode;
    e.col  = m_col;
    e.row  = m_row;
    e.sof  = (m_col == 0) && (m_row == 0);
    e.eol  = (m_col == COLS - 1);
    e.eof  = e.eol && (m_row == ROWS - 1);
    e.pix  = drop ? '0 : pix_of(24'(p0));
    e.cyc  = cyc;
    sb.push_back(e);
    if (m_col == COLS - 1) begin
      m_col = 0;
      m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
    @(negedge clk_in);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk_in);
    check("drain", sb.size(), 0);
  endtask

  task automatic model_reset();
    sb.delete();
    pend.delete();
    m_col = 0;
    m_row = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
  endtask

  initial begin
    int base;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    clr_err  = 1'b0;
    repeat (2) @(negedge clk_in);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_disp_valid", disp_valid, 4'b0000);
    check("rst_out_pix", out_pix, '0);
    check("rst_out_pos", {out_mode, out_col, out_row}, '0);
    check("rst_err", {err_missing, err_unexpected}, 2'b00);
    rst_n = 1'b1;
    @(negedge clk_in);

    // one word per mode, back to back
    send(0, 1, 1'b0);
    send(1, 2, 1'b0);
    send(2, 3, 1'b0);
    send(3, 4, 1'b0);
    drain();
    check("basic_err", {err_missing, err_unexpected}, 2'b00);

    // full frame plus one word, checking the frame markers and wrap
    do_reset();
    for (int i = 0; i < COLS * ROWS + 1; i++) send(1, i, 1'b0);
    drain();
    check("frame_err", {err_missing, err_unexpected}, 2'b00);

    // mode 1 returns overtake the preceding mode 0 returns
    base = n_out;
    for (int i = 0; i < 40; i++) send(i % 2, 100 + i, 1'b0);
    drain();
    check("alt_count", n_out - base, 40);
    check("alt_err", {err_missing, err_unexpected}, 2'b00);

    // one SP2 word without a return
    send(3, 300, 1'b0);
    send(2, 301, 1'b1);
    send(1, 302, 1'b0);
    in_valid = 1'b0;
    for (int k = 2; k <= 6; k++) begin
      check("miss_early", err_missing, 1'b0);
      @(negedge clk_in);
    end
    check("miss_set", err_missing, 1'b1);
    clr_err = 1'b1;
    @(negedge clk_in);
    clr_err = 1'b0;
    check("miss_clr", err_missing, 1'b0);
    drain();
    check("miss_unexp", err_unexpected, 1'b0);

    // spurious returns, the second one coinciding with a clear
    idle(4);
    spur_req = 1'b1;
    @(negedge clk_in);
    spur_req = 1'b0;
    check("unexp_early", err_unexpected, 1'b0);
    @(negedge clk_in);
    check("unexp_set", err_unexpected, 1'b1);
    spur_req = 1'b1;
    @(negedge clk_in);
    spur_req = 1'b0;
    clr_err  = 1'b1;
    @(negedge clk_in);
    clr_err = 1'b0;
    check("unexp_set_wins", err_unexpected, 1'b1);
    clr_err = 1'b1;
    @(negedge clk_in);
    clr_err = 1'b0;
    check("unexp_clr", err_unexpected, 1'b0);
    check("unexp_missing", err_missing, 1'b0);
    idle(3);

    // reset with five words in flight
    for (int i = 0; i < 5; i++) send(i % 4, 200 + i, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_disp", {disp_valid, disp_data}, '0);
    check("mid_rst_out_pix", out_pix, '0);
    check("mid_rst_out_pos", {out_mode, out_col, out_row, out_sof, out_eol, out_eof}, '0);
    check("mid_rst_err", {err_missing, err_unexpected}, 2'b00);
    model_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    idle(3);
    send(2, 400, 1'b0);
    in_valid = 1'b0;
    for (int k = 1; k < LAT_TOTAL; k++) begin
      check("post_rst_quiet", out_valid, 1'b0);
      @(negedge clk_in);
    end
    check("post_rst_first", out_valid, 1'b1);
    drain();
    check("post_rst_err", {err_missing, err_unexpected}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
